image_writer: RTL and testbench

Frame-capture sink for the image-processing pipeline. Accepts the two-pixels-per-cycle RGB stream produced by the image source/processing stage, qualified by VSYNC and HSYNC. Stores each frame into an internal byte buffer in the same bottom-up, R-G-B-per-pixel layout the source reads from its hex file, so a captured frame can be round-tripped. Exposes a registered read port and a frame-done flag so a bench or downstream block can dump the result.

---
 rtl/image_writer.sv | 169 ++++++++++++++++
 tb/tb_image_writer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_writer.sv
// -----------------------------------------------------------------------------
// image_writer
//   Frame-capture sink for the two-pixels-per-cycle RGB stream. Each beat
//   carries an even/odd pixel pair and is stored into an internal byte buffer
//   in bottom-up row order with R,G,B per pixel, which is the same layout the
//   image source reads, so a captured frame can be round-tripped.
//
// Parameters
//   WIDTH   pixels per row (even)
//   HEIGHT  rows per frame
//
// Ports
//   HCLK        clock, rising edge
//   HRESET      synchronous active-high reset (buffer contents kept)
//   VSYNC       frame start; restarts capture from row 0 in any state
//   HSYNC       beat valid
//   DATA_*0     even-column pixel of the beat
//   DATA_*1     odd-column pixel of the beat
//   RD_ADDR     buffer byte address for readout
//   RD_DATA     registered byte at RD_ADDR (one cycle latency, read-before-write)
//   FRAME_DONE  level, high once a full frame is stored
//   DROP        sticky, a beat arrived while not capturing
// -----------------------------------------------------------------------------
module image_writer #(
  parameter int WIDTH  = 340,
  parameter int HEIGHT = 230,
  localparam int ADDR_W = $clog2(WIDTH * HEIGHT * 3)
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              VSYNC,
  input  logic              HSYNC,
  input  logic [7:0]        DATA_R0,
  input  logic [7:0]        DATA_G0,
  input  logic [7:0]        DATA_B0,
  input  logic [7:0]        DATA_R1,
  input  logic [7:0]        DATA_G1,
  input  logic [7:0]        DATA_B1,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic [7:0]        RD_DATA,
  output logic              FRAME_DONE,
  output logic              DROP
);

  localparam int BYTES = WIDTH * HEIGHT * 3;
  localparam int COL_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = $clog2(HEIGHT + 1);

  localparam logic [18:0]       FRAME_BEATS = 19'(WIDTH * HEIGHT / 2);
  localparam logic [COL_W-1:0]  COL_LAST    = COL_W'(WIDTH - 2);
  localparam logic [COL_W-1:0]  COL_STEP    = COL_W'(2);
  localparam logic [ADDR_W-1:0] ROW_BYTES   = ADDR_W'(WIDTH * 3);
  localparam logic [ADDR_W-1:0] LAST_ROW    = ADDR_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] PIX_BYTES   = ADDR_W'(3);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [18:0]       beat_cnt_r;
  logic [COL_W-1:0]  col_r;
  logic [ROW_W-1:0]  row_r;
  logic              frame_done_r;
  logic              drop_r;
  logic [7:0]        rd_data_r;
  logic              store_s;
  logic              drop_set_s;
  logic              last_beat_s;
  logic [ADDR_W-1:0] row_ext_s;
  logic [ADDR_W-1:0] col_ext_s;
  logic [ADDR_W-1:0] base_s;

  logic [7:0] mem_r [0:BYTES-1];

  // The beat counter alone decides frame completion; row/col only steer addresses.
  assign last_beat_s = (beat_cnt_r == (FRAME_BEATS - 19'd1));

  // Bottom-up layout: row 0 of the stream lands in the last buffer row.
  assign row_ext_s = ADDR_W'(row_r);
  assign col_ext_s = ADDR_W'(col_r);
  assign base_s    = ROW_BYTES * (LAST_ROW - row_ext_s) + PIX_BYTES * col_ext_s;

  // Next-state and beat qualification; VSYNC wins over HSYNC in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    store_s     = 1'b0;
    drop_set_s  = 1'b0;
    if (VSYNC) begin
      state_nxt_s = ST_ARMED;
    end else if (HSYNC) begin
      case (state_r)
        ST_ARMED, ST_CAPTURE: begin
          store_s = 1'b1;
          if (last_beat_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_CAPTURE;
          end
        end
        ST_IDLE, ST_DONE: begin
          drop_set_s = 1'b1;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Control state, address counters and status flags.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_r      <= ST_IDLE;
      beat_cnt_r   <= 19'd0;
      col_r        <= '0;
      row_r        <= '0;
      frame_done_r <= 1'b0;
      drop_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      frame_done_r <= (state_nxt_s == ST_DONE);
      drop_r       <= drop_r | drop_set_s;
      if (VSYNC) begin
        beat_cnt_r <= 19'd0;
        col_r      <= '0;
        row_r      <= '0;
      end else if (store_s) begin
        beat_cnt_r <= beat_cnt_r + 19'd1;
        if (col_r == COL_LAST) begin
          col_r <= '0;
          row_r <= row_r + ROW_W'(1);
        end else begin
          col_r <= col_r + COL_STEP;
        end
      end
    end
  end

  // Pixel-pair write: all six bytes land on the edge that samples the beat.
  always_ff @(posedge HCLK) begin
    if (!HRESET && store_s) begin
      mem_r[base_s]                <= DATA_R0;
      mem_r[base_s + ADDR_W'(1)]   <= DATA_G0;
      mem_r[base_s + ADDR_W'(2)]   <= DATA_B0;
      mem_r[base_s + ADDR_W'(3)]   <= DATA_R1;
      mem_r[base_s + ADDR_W'(4)]   <= DATA_G1;
      mem_r[base_s + ADDR_W'(5)]   <= DATA_B1;
    end
  end

  // Registered readout; a same-edge write is not forwarded, so the old byte returns.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rd_data_r <= 8'd0;
    end else begin
      rd_data_r <= mem_r[RD_ADDR];
    end
  end

  assign RD_DATA    = rd_data_r;
  assign FRAME_DONE = frame_done_r;
  assign DROP       = drop_r;

endmodule

// File: tb/tb_image_writer.sv
// -----------------------------------------------------------------------------
// tb_image_writer
//   Drives a 4x2 instance through directed frame scenarios while a behavioural
//   model (beat index -> row/col -> byte address) tracks the expected buffer and
//   flags; a compare process checks FRAME_DONE, DROP and RD_DATA every cycle.
//   A default 340x230 instance receives one full ramp frame.
// -----------------------------------------------------------------------------
module tb_image_writer;

  localparam int SW = 4;
  localparam int SH = 2;
  localparam int SBYTES = SW * SH * 3;
  localparam int LBEATS = 340 * 230 / 2;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // small instance signals
  logic       s_rst, s_vs, s_hs;
  logic [7:0] s_r0, s_g0, s_b0, s_r1, s_g1, s_b1;
  logic [4:0] s_addr;
  logic [7:0] s_rd;
  logic       s_fd, s_drop;

  // large instance signals
  logic        l_rst, l_vs, l_hs;
  logic [7:0]  l_r0, l_g0, l_b0, l_r1, l_g1, l_b1;
  logic [17:0] l_addr;
  logic [7:0]  l_rd;
  logic        l_fd, l_drop;

  image_writer #(.WIDTH(SW), .HEIGHT(SH)) u_small (
    .HCLK(HCLK), .HRESET(s_rst), .VSYNC(s_vs), .HSYNC(s_hs),
    .DATA_R0(s_r0), .DATA_G0(s_g0), .DATA_B0(s_b0),
    .DATA_R1(s_r1), .DATA_G1(s_g1), .DATA_B1(s_b1),
    .RD_ADDR(s_addr), .RD_DATA(s_rd), .FRAME_DONE(s_fd), .DROP(s_drop)
  );

  image_writer u_large (
    .HCLK(HCLK), .HRESET(l_rst), .VSYNC(l_vs), .HSYNC(l_hs),
    .DATA_R0(l_r0), .DATA_G0(l_g0), .DATA_B0(l_b0),
    .DATA_R1(l_r1), .DATA_G1(l_g1), .DATA_B1(l_b1),
    .RD_ADDR(l_addr), .RD_DATA(l_rd), .FRAME_DONE(l_fd), .DROP(l_drop)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model state for the small instance
  logic [7:0] m_mem [0:SBYTES-1];
  bit         m_val [0:SBYTES-1];
  int         m_mode;      // 0 waiting, 1 armed, 2 capturing, 3 complete
  int         m_beats;
  bit         m_fd, m_drop;
  logic [7:0] m_rd;
  bit         m_rd_v;
  bit         chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply one clock edge to the model using the inputs the DUT just sampled.
  task automatic model_update();
    int r, c, base;
    if (s_rst) begin
      m_mode = 0; m_beats = 0; m_fd = 1'b0; m_drop = 1'b0;
      m_rd = 8'h00; m_rd_v = 1'b1;
    end else begin
      m_rd   = m_mem[s_addr];
      m_rd_v = m_val[s_addr];
      if (s_vs) begin
        m_mode = 1; m_beats = 0; m_fd = 1'b0;
      end else if (s_hs) begin
        if (m_mode == 0 || m_mode == 3) begin
          m_drop = 1'b1;
        end else begin
          r    = m_beats / (SW / 2);
          c    = 2 * (m_beats % (SW / 2));
          base = SW * 3 * (SH - 1 - r) + 3 * c;
          m_mem[base]   = s_r0; m_mem[base+1] = s_g0; m_mem[base+2] = s_b0;
          m_mem[base+3] = s_r1; m_mem[base+4] = s_g1; m_mem[base+5] = s_b1;
          for (int i = 0; i < 6; i++) m_val[base+i] = 1'b1;
          m_beats++;
          m_mode = 2;
          if (m_beats == SW * SH / 2) begin
            m_mode = 3; m_fd = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    model_update();
    #1;
  endtask

  task automatic idle(input int n);
    s_hs = 1'b0; s_vs = 1'b0;
    repeat (n) step();
  endtask

  task automatic vsync(input int n);
    s_vs = 1'b1;
    repeat (n) step();
    s_vs = 1'b0;
  endtask

  task automatic beat(input logic [7:0] b, input int k);
    logic [7:0] kk;
    kk = 8'(k);
    s_r0 = b + kk;          s_g0 = b + 8'h10 + kk; s_b0 = b + 8'h20 + kk;
    s_r1 = b + 8'h30 + kk;  s_g1 = b + 8'h40 + kk; s_b1 = b + 8'h50 + kk;
    s_hs = 1'b1;
    step();
    s_hs = 1'b0;
  endtask

  task automatic read_chk(input string nm, input int addr, input logic [7:0] exp);
    s_addr = 5'(addr);
    step();
    check(nm, s_rd, exp);
    check({nm, "_model"}, m_mem[addr], exp);
  endtask

  task automatic sweep();
    for (int a = 0; a < SBYTES; a++) begin
      s_addr = 5'(a);
      step();
    end
  endtask

  // Per-cycle comparison of the small instance against the model.
  initial begin
    forever begin
      @(negedge HCLK);
      if (chk_en) begin
        check("cyc_frame_done", s_fd, m_fd);
        check("cyc_drop", s_drop, m_drop);
        if (m_rd_v) check("cyc_rd_data", s_rd, m_rd);
      end
    end
  end

  initial begin
    for (int i = 0; i < SBYTES; i++) begin
      m_val[i] = 1'b0;
      m_mem[i] = 8'h00;
    end
    m_mode = 0; m_beats = 0; m_fd = 1'b0; m_drop = 1'b0; m_rd = 8'h00; m_rd_v = 1'b0;
    s_rst = 1'b1; s_vs = 1'b0; s_hs = 1'b0; s_addr = 5'd0;
    s_r0 = 8'h00; s_g0 = 8'h00; s_b0 = 8'h00; s_r1 = 8'h00; s_g1 = 8'h00; s_b1 = 8'h00;
    l_rst = 1'b1; l_vs = 1'b0; l_hs = 1'b0; l_addr = 18'd0;
    l_r0 = 8'h00; l_g0 = 8'h00; l_b0 = 8'h00; l_r1 = 8'h00; l_g1 = 8'h00; l_b1 = 8'h00;

    // reset
    step();
    chk_en = 1'b1;
    step();
    s_rst = 1'b0; l_rst = 1'b0;
    check("rst_frame_done", s_fd, 1'b0);
    check("rst_drop", s_drop, 1'b0);
    check("rst_rd_data", s_rd, 8'h00);

    // first frame, back-to-back beats
    vsync(3);
    for (int k = 0; k < 4; k++) begin
      beat(8'h10, k);
      if (k == 2) check("f1_done_early", s_fd, 1'b0);
    end
    check("f1_done", s_fd, 1'b1);
    check("f1_drop", s_drop, 1'b0);
    read_chk("f1_b12", 12, 8'h10);
    read_chk("f1_b13", 13, 8'h20);
    read_chk("f1_b14", 14, 8'h30);
    read_chk("f1_b15", 15, 8'h40);
    read_chk("f1_b0",  0,  8'h12);
    read_chk("f1_b9",  9,  8'h43);

    // same frame with idle gaps
    vsync(1);
    check("f2_done_cleared", s_fd, 1'b0);
    for (int k = 0; k < 4; k++) begin
      beat(8'h10, k);
      if (k < 3) begin
        check("f2_done_mid", s_fd, 1'b0);
        idle((k % 3) + 1);
      end
    end
    check("f2_done", s_fd, 1'b1);
    sweep();
    read_chk("f2_b9", 9, 8'h43);

    // beats while not capturing
    s_rst = 1'b1; step(); s_rst = 1'b0;
    check("d_rst_drop", s_drop, 1'b0);
    beat(8'hEE, 0);
    idle(1);
    beat(8'hEE, 1);
    check("d_drop_idle", s_drop, 1'b1);
    read_chk("d_b12", 12, 8'h10);
    read_chk("d_b0",  0,  8'h12);
    vsync(1);
    check("d_drop_after_vsync", s_drop, 1'b1);
    for (int k = 0; k < 4; k++) beat(8'h10, k);
    beat(8'hEE, 4);
    check("d_done_kept", s_fd, 1'b1);
    check("d_drop_done", s_drop, 1'b1);
    read_chk("d_b12_kept", 12, 8'h10);

    // aborted frame followed by a fresh frame
    vsync(1);
    beat(8'h10, 0);
    beat(8'h10, 1);
    vsync(1);
    s_addr = 5'd12;
    beat(8'h90, 0);
    check("a_rd_old", s_rd, 8'h10);
    beat(8'h90, 1);
    check("a_rd_new", s_rd, 8'h90);
    beat(8'h90, 2);
    check("a_done_low", s_fd, 1'b0);
    beat(8'h90, 3);
    check("a_done", s_fd, 1'b1);
    check("a_drop", s_drop, 1'b1);
    sweep();
    read_chk("a_b0",  0,  8'h92);
    read_chk("a_b23", 23, 8'hE1);

    // reset mid-frame
    vsync(1);
    for (int k = 0; k < 3; k++) beat(8'h50, k);
    s_addr = 5'd12;
    s_rst = 1'b1; step(); s_rst = 1'b0;
    check("r_frame_done", s_fd, 1'b0);
    check("r_rd_data", s_rd, 8'h00);
    check("r_drop", s_drop, 1'b0);
    beat(8'h77, 0);
    check("r_drop_idle", s_drop, 1'b1);
    read_chk("r_b12", 12, 8'h50);
    read_chk("r_b18", 18, 8'h51);
    read_chk("r_b0",  0,  8'h52);

    // full-size frame with a ramp on the default instance
    l_vs = 1'b1; step(); l_vs = 1'b0;
    for (int n = 0; n < LBEATS; n++) begin
      l_r0 = 8'(n);     l_g0 = 8'(n + 1); l_b0 = 8'(n + 2);
      l_r1 = 8'(n + 3); l_g1 = 8'(n + 4); l_b1 = 8'(n + 5);
      l_hs = 1'b1;
      step();
      if (n == LBEATS - 2) check("l_done_early", l_fd, 1'b0);
    end
    l_hs = 1'b0;
    check("l_done", l_fd, 1'b1);
    check("l_drop", l_drop, 1'b0);
    l_addr = 18'd0;      step();
    check("l_b0", l_rd, 8'h12);
    l_addr = 18'd234599; step();
    check("l_b234599", l_rd, 8'hAE);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
